// File: rtl/matrix_pkg.sv
// ----------------------------------------------------------------------------
// matrix_pkg
//   Shared constants, types and helpers for the 2-column x 4-row LED matrix
//   scan controller.
//
//   NCOL / NROW    matrix geometry
//   COL_ON         level that drives a column (active high)
//   ROW_ON         level that lights a row (active low)
//   scan_state_t   slot phase: S_BLANK (dark gap) or S_DRIVE (column lit)
//   sw_index(r,c)  switch bit that lights row r of column c
// ----------------------------------------------------------------------------
package matrix_pkg;

  localparam int NCOL = 2;
  localparam int NROW = 4;
  localparam int NSW  = NCOL * NROW;

  localparam logic COL_ON = 1'b1;
  localparam logic ROW_ON = 1'b0;

  // Slot phase encoding, kept as plain constants so the state value is easy
  // to compare and to expose on a debug port.
  typedef logic [0:0] scan_state_t;
  localparam scan_state_t S_BLANK = 1'b0;
  localparam scan_state_t S_DRIVE = 1'b1;

  // Even switches feed column 0, odd switches feed column 1.
  function automatic int sw_index(input int r, input int c);
    return 2 * r + c;
  endfunction

endpackage

// File: rtl/sync_ff2.sv
// ----------------------------------------------------------------------------
// sync_ff2
//   Two-flop synchroniser for a bus of independent, quasi-static inputs
//   (board switches). Each bit is synchronised on its own; no coherency
//   between bits is implied.
//
//   clk    in   1      destination clock, rising edge
//   rst_n  in   1      asynchronous, active-low reset (clears both stages)
//   d      in   WIDTH  asynchronous inputs
//   q      out  WIDTH  synchronised outputs, two clk cycles behind d
// ----------------------------------------------------------------------------
module sync_ff2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/matrix_scan_controller.sv
// ----------------------------------------------------------------------------
// matrix_scan_controller
//   Time-multiplexed scan controller for a 2-column x 4-row LED matrix.
//   Switch inputs are synchronised, snapshotted once per frame, and shown one
//   column at a time. Every column slot is DIV cycles long and starts with
//   BLANK dark cycles so the previous column's rows never ghost onto the next.
//
//   Clock       in   1  system clock, rising edge
//   Reset_n     in   1  asynchronous, active-low reset
//   Enable      in   1  1 = scan runs, 0 = matrix dark (snapshot held)
//   CH          in   8  raw switch inputs, asynchronous to Clock
//   Coluna      out  2  column drive, active high, one-hot or 00
//   Linha       out  4  row drive, active low
//   FrameStart  out  1  one-cycle pulse when a new snapshot is loaded
//   scan_state  out  1  debug: slot phase decoded from the current counter
//
//   Parameters: DIV   cycles per column slot (DIV >= 4)
//               BLANK dark cycles at slot start (1 <= BLANK < DIV)
// ----------------------------------------------------------------------------
module matrix_scan_controller
  import matrix_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 16
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Enable,
  input  logic [7:0]  CH,
  output logic [1:0]  Coluna,
  output logic [3:0]  Linha,
  output logic        FrameStart,
  output scan_state_t scan_state
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int ROW_W = (NROW > 1) ? $clog2(NROW) : 1;
  localparam int SW_W  = (NSW > 1) ? $clog2(NSW) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);

  // --------------------------------------------------------------------------
  // Input synchronisation
  // --------------------------------------------------------------------------
  logic [NSW-1:0] ch_sync;

  sync_ff2 #(
    .WIDTH (NSW)
  ) u_sync (
    .clk   (Clock),
    .rst_n (Reset_n),
    .d     (CH),
    .q     (ch_sync)
  );

  // --------------------------------------------------------------------------
  // Scan state
  //   running  : scan was active on the previous edge; a 0 here while Enable
  //              is high means this edge is the first enabled cycle and must
  //              start a fresh frame.
  //   cnt      : position inside the current column slot
  //   col      : column currently being scanned
  //   snap     : switch image shown for the whole frame
  // --------------------------------------------------------------------------
  logic             running;
  logic [CNT_W-1:0] cnt;
  logic             col;
  logic [NSW-1:0]   snap;

  logic slot_end;
  logic frame_wrap;

  assign slot_end   = (cnt == CNT_LAST);
  assign frame_wrap = slot_end && col;

  // Slot phase is a pure decode of the counter; the output registers below
  // turn it into pin levels one cycle later, so each phase lasts exactly
  // BLANK or DIV-BLANK cycles on the pins.
  always_comb begin
    scan_state = S_DRIVE;
    if (cnt < CNT_BLANK) begin
      scan_state = S_BLANK;
    end
  end

  // --------------------------------------------------------------------------
  // Next pin pattern for the current counter position
  // --------------------------------------------------------------------------
  logic [NCOL-1:0] col_drive;
  logic [NROW-1:0] row_drive;

  always_comb begin
    col_drive = '0;
    row_drive = {NROW{~ROW_ON}};
    if (scan_state == S_DRIVE) begin
      col_drive[col] = COL_ON;
      for (int r = 0; r < NROW; r++) begin
        if (snap[SW_W'(sw_index(r, int'(col)))]) begin
          row_drive[ROW_W'(r)] = ROW_ON;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Counter, column, snapshot
  //   Enable low has priority over everything, including a frame wrap in the
  //   same cycle. The snapshot register is the only path from CH to the pins,
  //   so a switch change mid-frame waits for the next frame boundary.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      running <= 1'b0;
      cnt     <= '0;
      col     <= 1'b0;
      snap    <= '0;
    end else if (!Enable) begin
      running <= 1'b0;
      cnt     <= '0;
      col     <= 1'b0;
    end else if (!running) begin
      running <= 1'b1;
      cnt     <= '0;
      col     <= 1'b0;
      snap    <= ch_sync;
    end else if (slot_end) begin
      cnt <= '0;
      col <= ~col;
      if (frame_wrap) begin
        snap <= ch_sync;
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Output registers
  //   The first enabled cycle shows dark pins (nothing has been decoded yet);
  //   after that the pins follow the decoded pattern of the previous counter
  //   value.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Coluna     <= '0;
      Linha      <= '1;
      FrameStart <= 1'b0;
    end else if (!Enable) begin
      Coluna     <= '0;
      Linha      <= '1;
      FrameStart <= 1'b0;
    end else if (!running) begin
      Coluna     <= '0;
      Linha      <= '1;
      FrameStart <= 1'b1;
    end else begin
      Coluna     <= col_drive;
      Linha      <= row_drive;
      FrameStart <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_matrix_scan_controller.sv
// ----------------------------------------------------------------------------
// tb_matrix_scan_controller
//   Directed bench for matrix_scan_controller with DIV=8, BLANK=2.
//   Pins are observed as one 7-bit word {Coluna, Linha, FrameStart} on the
//   falling edge of Clock, half a cycle after the registers update.
//
//   Frame timeline relative to the FrameStart edge (edge 0):
//     edges 1..2    dark
//     edges 3..8    column 0 lit
//     edges 9..10   dark
//     edges 11..16  column 1 lit, edge 16 also carries the next FrameStart
// ----------------------------------------------------------------------------
module tb_matrix_scan_controller;

  import matrix_pkg::*;

  localparam int DIV   = 8;
  localparam int BLANK = 2;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Enable;
  logic [7:0]  CH;
  logic [1:0]  Coluna;
  logic [3:0]  Linha;
  logic        FrameStart;
  scan_state_t scan_state;

  always #5 Clock = ~Clock;

  matrix_scan_controller #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Enable     (Enable),
    .CH         (CH),
    .Coluna     (Coluna),
    .Linha      (Linha),
    .FrameStart (FrameStart),
    .scan_state (scan_state)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] DARK_ROWS = 4'b1111;

  function automatic logic [6:0] mk(input logic [1:0] c, input logic [3:0] l,
                                    input logic f);
    return {c, l, f};
  endfunction

  // --------------------------------------------------------------------------
  // Driver / check tasks
  // --------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic check(input string tag, input logic [6:0] expected);
    logic [6:0] observed;
    observed = {Coluna, Linha, FrameStart};
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed col=%b row=%b fs=%b expected col=%b row=%b fs=%b",
             tag, observed[6:5], observed[4:1], observed[0],
             expected[6:5], expected[4:1], expected[0]);
    end
  endtask

  // Walks ncyc edges of a frame that began at the last FrameStart edge.
  // l0/l1 are the hand-computed row levels for columns 0 and 1.
  // When chg is set, CH is changed to nch after edge 4 (mid column-0 drive).
  task automatic frame(input string tag, input logic [3:0] l0,
                       input logic [3:0] l1, input logic chg,
                       input logic [7:0] nch, input int ncyc);
    logic [6:0] exp_v;
    for (int i = 1; i <= ncyc; i++) begin
      cyc(1);
      if (i <= 2)       exp_v = mk(2'b00, DARK_ROWS, 1'b0);
      else if (i <= 8)  exp_v = mk(2'b01, l0, 1'b0);
      else if (i <= 10) exp_v = mk(2'b00, DARK_ROWS, 1'b0);
      else              exp_v = mk(2'b10, l1, (i == 16));
      check($sformatf("%s_e%0d", tag, i), exp_v);
      if (chg && i == 4) CH = nch;
    end
  endtask

  // --------------------------------------------------------------------------
  // Always-on pin invariants
  // --------------------------------------------------------------------------
  logic prev_fs = 1'b0;

  always @(negedge Clock) begin
    checks++;
    assert (Coluna !== 2'b11) else begin
      errors++;
      $error("FAIL inv_col11 observed col=%b expected one-hot or 00", Coluna);
    end
    checks++;
    assert (Coluna !== 2'b00 || Linha === 4'b1111) else begin
      errors++;
      $error("FAIL inv_dark_rows observed row=%b expected 1111 with col=00", Linha);
    end
    checks++;
    assert (!(prev_fs === 1'b1 && FrameStart === 1'b1)) else begin
      errors++;
      $error("FAIL inv_fs_double observed fs high twice expected single pulse");
    end
    prev_fs = FrameStart;
  end

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    Reset_n = 1'b1;
    Enable  = 1'b1;
    CH      = 8'hFF;
    #1 Reset_n = 1'b0;

    // Held in reset with all switches on and Enable high: stays dark.
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check($sformatf("s1_reset_%0d", i), mk(2'b00, DARK_ROWS, 1'b0));
    end
    CH = 8'h55;
    cyc(1);
    check("s1_reset_ch55", mk(2'b00, DARK_ROWS, 1'b0));
    Reset_n = 1'b1;

    // First enabled edge starts a frame with the still-cleared synchroniser.
    cyc(1);
    check("s2_fs0", mk(2'b00, DARK_ROWS, 1'b1));
    frame("s2_f0", 4'b1111, 4'b1111, 1'b0, 8'h00, 16);
    // 0x55: even switches only -> column 0 fully lit, column 1 dark rows.
    frame("s2_f1", 4'b0000, 4'b1111, 1'b0, 8'h00, 16);

    // Mid-frame change to 0xAA must not disturb the frame in progress.
    frame("s4_f2", 4'b0000, 4'b1111, 1'b1, 8'hAA, 16);
    // 0xAA shown now; 0x82 applied mid-frame for the next one.
    frame("s4_f3", 4'b1111, 4'b0000, 1'b1, 8'h82, 16);
    // 0x82: bits 1 and 7 -> column 1 rows 0 and 3.
    frame("s3_f4", 4'b1111, 4'b0110, 1'b0, 8'h00, 16);

    // Drop Enable during column-1 drive.
    frame("s5_pre", 4'b1111, 4'b0110, 1'b0, 8'h00, 11);
    Enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check($sformatf("s5_off_%0d", i), mk(2'b00, DARK_ROWS, 1'b0));
    end
    Enable = 1'b1;
    cyc(1);
    check("s5_restart_fs", mk(2'b00, DARK_ROWS, 1'b1));
    frame("s5_f0", 4'b1111, 4'b0110, 1'b0, 8'h00, 16);

    // Enable drops on the very edge that would wrap the frame: no FrameStart.
    frame("s5_wrap", 4'b1111, 4'b0110, 1'b0, 8'h00, 15);
    Enable = 1'b0;
    cyc(1);
    check("s5_wrap_off", mk(2'b00, DARK_ROWS, 1'b0));
    cyc(1);
    check("s5_wrap_off2", mk(2'b00, DARK_ROWS, 1'b0));
    Enable = 1'b1;
    cyc(1);
    check("s6_fs", mk(2'b00, DARK_ROWS, 1'b1));
    cyc(3);
    check("s6_drive", mk(2'b01, 4'b1111, 1'b0));

    // Asynchronous reset pulse between clock edges during drive.
    #1 Reset_n = 1'b0;
    #1 check("s6_async_dark", mk(2'b00, DARK_ROWS, 1'b0));
    #1 Reset_n = 1'b1;
    cyc(1);
    check("s6_fs0", mk(2'b00, DARK_ROWS, 1'b1));
    frame("s6_f0", 4'b1111, 4'b1111, 1'b0, 8'h00, 16);
    frame("s6_f1", 4'b1111, 4'b0110, 1'b0, 8'h00, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
